carry_look_ahead_adder: RTL and testbench

CARRY_LOOK_AHEAD_ADDER -- requirements
Module: carry_look_ahead_adder

---
 rtl/cla_pkg.sv | 74 +++++++
 rtl/cla_block4.sv | 33 +++
 rtl/carry_look_ahead_adder.sv | 130 +++++++++++++
 tb/tb_carry_look_ahead_adder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead adder.
//   CLA_GROUP        : width of one lookahead group (bits)
//   cla_gp_t         : packed group (generate, propagate) pair
//   cla_num_groups   : number of 4-bit groups for a given operand width
//   cla_num_levels   : number of radix-4 tree levels above the group level
//   cla_level_nodes  : number of tree nodes at a given level
//   cla_carries      : 4-way lookahead carry equations
//   cla_carry_at     : one carry from cla_carries (for the tree)
//   cla_group_gp     : 4-way group (G,P) reduction
package cla_pkg;

    localparam int unsigned CLA_GROUP = 4;

    typedef struct packed {
        logic g;
        logic p;
    } cla_gp_t;

    function automatic int unsigned cla_num_groups(input int unsigned numbits);
        return numbits / CLA_GROUP;
    endfunction

    function automatic int unsigned cla_num_levels(input int unsigned ngroups);
        int unsigned n;
        int unsigned lv;
        n  = ngroups;
        lv = 0;
        while (n > 1) begin
            n  = (n + CLA_GROUP - 1) / CLA_GROUP;
            lv = lv + 1;
        end
        return lv;
    endfunction

    function automatic int unsigned cla_level_nodes(input int unsigned ngroups,
                                                    input int unsigned level);
        int unsigned n;
        n = ngroups;
        for (int unsigned i = 0; i < level; i++) begin
            n = (n + CLA_GROUP - 1) / CLA_GROUP;
        end
        return n;
    endfunction

    // Carry into each of four positions, flattened to two-level logic so no
    // carry ripples through a neighbour.
    function automatic logic [3:0] cla_carries(input logic [2:0] g,
                                               input logic [2:0] p,
                                               input logic       cin);
        logic [3:0] c;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

    function automatic logic cla_carry_at(input logic [2:0]  g,
                                          input logic [2:0]  p,
                                          input logic        cin,
                                          input int unsigned pos);
        logic [3:0] c;
        c = cla_carries(g, p, cin);
        return c[pos];
    endfunction

    function automatic cla_gp_t cla_group_gp(input logic [3:0] g, input logic [3:0] p);
        cla_gp_t gp;
        gp.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        gp.p = &p;
        return gp;
    endfunction

endpackage

// File: rtl/cla_block4.sv
// 4-bit carry-lookahead group.
//   a, b    : 4-bit operand slices
//   cin     : carry into bit 0 of the group
//   sum     : 4-bit sum slice
//   group_g : group generate (group produces a carry on its own)
//   group_p : group propagate (group passes cin through)
module cla_block4
    import cla_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       group_g,
    output logic       group_p
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    cla_gp_t    gp;

    assign g   = a & b;
    assign p   = a ^ b;
    assign c   = cla_carries(g[2:0], p[2:0], cin);
    assign sum = p ^ c;

    // G/P do not depend on cin, so the tree above never waits on this group's carry.
    assign gp      = cla_group_gp(g, p);
    assign group_g = gp.g;
    assign group_p = gp.p;

endmodule

// File: rtl/carry_look_ahead_adder.sv
// Carry-lookahead adder: {carryout, result} = A + B + carryin (unsigned).
//   NUMBITS  : operand width, multiple of 4 (4..128)
//   clk      : clock (used only when CLA_OUTREG_EN is defined)
//   reset    : synchronous active-low reset (only with CLA_OUTREG_EN)
//   A, B     : operands
//   carryin  : carry into bit 0
//   result   : sum bits
//   carryout : carry out of the MSB
// Build option: define CLA_OUTREG_EN to register result/carryout (1-cycle latency).
// Without it the block is purely combinational.
module carry_look_ahead_adder
    import cla_pkg::*;
#(
    parameter int unsigned NUMBITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUMBITS-1:0] A,
    input  logic [NUMBITS-1:0] B,
    input  logic               carryin,
    output logic [NUMBITS-1:0] result,
    output logic               carryout
);

    localparam int unsigned NumGroups = cla_num_groups(NUMBITS);
    localparam int unsigned NumLevels = cla_num_levels(NumGroups);

    logic [NumGroups-1:0] blk_g;
    logic [NumGroups-1:0] blk_p;
    logic [NumGroups-1:0] blk_cin;
    logic [NUMBITS-1:0]   sum;
    logic                 cout;

    for (genvar i = 0; i < NumGroups; i++) begin : g_blk
        cla_block4 u_blk (
            .a       (A[CLA_GROUP*i +: CLA_GROUP]),
            .b       (B[CLA_GROUP*i +: CLA_GROUP]),
            .cin     (blk_cin[i]),
            .sum     (sum[CLA_GROUP*i +: CLA_GROUP]),
            .group_g (blk_g[i]),
            .group_p (blk_p[i])
        );
    end

    // Radix-4 lookahead tree. Level 0 holds the group (G,P) pairs; each level
    // above folds four nodes into one. Carries then flow back down: every node
    // gets its carry from its parent's carry plus its lower siblings' (G,P).
    for (genvar k = 0; k <= NumLevels; k++) begin : g_lvl
        localparam int unsigned Nodes = cla_level_nodes(NumGroups, k);

        logic [Nodes-1:0] gg;
        logic [Nodes-1:0] pp;
        logic [Nodes-1:0] cc;

        if (k == 0) begin : g_leaf
            assign gg      = blk_g;
            assign pp      = blk_p;
            assign blk_cin = cc;
        end else begin : g_up
            localparam int unsigned Kids = cla_level_nodes(NumGroups, k - 1);
            for (genvar j = 0; j < Nodes; j++) begin : g_node
                logic [3:0] kg;
                logic [3:0] kp;
                cla_gp_t    gp;
                for (genvar r = 0; r < CLA_GROUP; r++) begin : g_kid
                    if (CLA_GROUP * j + r < Kids) begin : g_real
                        assign kg[r] = g_lvl[k-1].gg[CLA_GROUP*j+r];
                        assign kp[r] = g_lvl[k-1].pp[CLA_GROUP*j+r];
                    end else begin : g_pad
                        // Identity pair: neither generates nor blocks a carry.
                        assign kg[r] = 1'b0;
                        assign kp[r] = 1'b1;
                    end
                end
                assign gp    = cla_group_gp(kg, kp);
                assign gg[j] = gp.g;
                assign pp[j] = gp.p;
            end
        end

        if (k == NumLevels) begin : g_root
            assign cc = carryin;
        end else begin : g_down
            for (genvar j = 0; j < Nodes; j++) begin : g_node
                localparam int unsigned Base = CLA_GROUP * (j / CLA_GROUP);
                localparam int unsigned Pos  = j % CLA_GROUP;
                logic [2:0] sg;
                logic [2:0] sp;
                for (genvar s = 0; s < CLA_GROUP - 1; s++) begin : g_sib
                    if (Base + s < Nodes) begin : g_real
                        assign sg[s] = gg[Base+s];
                        assign sp[s] = pp[Base+s];
                    end else begin : g_pad
                        assign sg[s] = 1'b0;
                        assign sp[s] = 1'b1;
                    end
                end
                assign cc[j] = cla_carry_at(sg, sp, g_lvl[k+1].cc[j/CLA_GROUP], Pos);
            end
        end
    end

    assign cout = g_lvl[NumLevels].gg[0] | (g_lvl[NumLevels].pp[0] & carryin);

`ifdef CLA_OUTREG_EN
    logic [NUMBITS-1:0] result_q;
    logic               carryout_q;

    // Reset wins over capture on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            result_q   <= '0;
            carryout_q <= 1'b0;
        end else begin
            result_q   <= sum;
            carryout_q <= cout;
        end
    end

    assign result   = result_q;
    assign carryout = carryout_q;
`else
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;

    assign result   = sum;
    assign carryout = cout;
`endif

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// Self-checking bench for carry_look_ahead_adder at widths 4..128.
// All six instances share one set of 128-bit operand registers, each taking
// its own low slice. Works in both the default and CLA_OUTREG_EN builds.
module tb_carry_look_ahead_adder;

`ifdef CLA_OUTREG_EN
    localparam bit OutReg = 1'b1;
`else
    localparam bit OutReg = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic [127:0] a_v;
    logic [127:0] b_v;
    logic         cin_v;

    logic [3:0]   r4;
    logic [7:0]   r8;
    logic [15:0]  r16;
    logic [31:0]  r32;
    logic [63:0]  r64;
    logic [127:0] r128;
    logic         co4, co8, co16, co32, co64, co128;

    int n_checks = 0;
    int n_pass   = 0;

    carry_look_ahead_adder #(.NUMBITS(4)) dut4 (
        .clk(clk), .reset(reset), .A(a_v[3:0]), .B(b_v[3:0]), .carryin(cin_v),
        .result(r4), .carryout(co4)
    );
    carry_look_ahead_adder #(.NUMBITS(8)) dut8 (
        .clk(clk), .reset(reset), .A(a_v[7:0]), .B(b_v[7:0]), .carryin(cin_v),
        .result(r8), .carryout(co8)
    );
    carry_look_ahead_adder #(.NUMBITS(16)) dut16 (
        .clk(clk), .reset(reset), .A(a_v[15:0]), .B(b_v[15:0]), .carryin(cin_v),
        .result(r16), .carryout(co16)
    );
    carry_look_ahead_adder #(.NUMBITS(32)) dut32 (
        .clk(clk), .reset(reset), .A(a_v[31:0]), .B(b_v[31:0]), .carryin(cin_v),
        .result(r32), .carryout(co32)
    );
    carry_look_ahead_adder #(.NUMBITS(64)) dut64 (
        .clk(clk), .reset(reset), .A(a_v[63:0]), .B(b_v[63:0]), .carryin(cin_v),
        .result(r64), .carryout(co64)
    );
    carry_look_ahead_adder #(.NUMBITS(128)) dut128 (
        .clk(clk), .reset(reset), .A(a_v), .B(b_v), .carryin(cin_v),
        .result(r128), .carryout(co128)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive operands, then sample 1 time unit after the next rising edge
    // (a registered build captures on that edge; a combinational one has long settled).
    task automatic apply(input logic [127:0] a, input logic [127:0] b, input logic c);
        a_v   = a;
        b_v   = b;
        cin_v = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp_r;
        logic       exp_co;
        exp_r  = OutReg ? 8'h00 : 8'h39;
        exp_co = OutReg ? 1'b0 : 1'b1;
        reset = 1'b0;
        apply(128'hD5, 128'h64, 1'b0);
        @(posedge clk);
        #1;
        n_checks++;
        if (r8 !== exp_r) $display("FAIL reset_r8: got %h want %h", r8, exp_r);
        else n_pass++;
        n_checks++;
        if (co8 !== exp_co) $display("FAIL reset_co8: got %b want %b", co8, exp_co);
        else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_width4();
        logic [3:0] ta [5];
        logic [3:0] tb [5];
        logic [3:0] er [5];
        logic       ec [5];
        ta = '{4'd0, 4'd7, 4'd15, 4'd12, 4'd12};
        tb = '{4'd0, 4'd1, 4'd1,  4'd2,  4'd6};
        er = '{4'd0, 4'd8, 4'd0,  4'd14, 4'd2};
        ec = '{1'b0, 1'b0, 1'b1,  1'b0,  1'b1};
        for (int i = 0; i < 5; i++) begin
            apply({124'd0, ta[i]}, {124'd0, tb[i]}, 1'b0);
            n_checks++;
            if (r4 !== er[i]) $display("FAIL w4_result[%0d]: got %0d want %0d", i, r4, er[i]);
            else n_pass++;
            n_checks++;
            if (co4 !== ec[i]) $display("FAIL w4_carry[%0d]: got %b want %b", i, co4, ec[i]);
            else n_pass++;
        end
    endtask

    task automatic test_width8();
        logic [7:0] ta [6];
        logic [7:0] tb [6];
        logic       tc [6];
        logic [7:0] er [6];
        logic       ec [6];
        // Last two rows exercise carryin=1.
        ta = '{8'h00, 8'hFF, 8'h0B, 8'hD5, 8'h7F, 8'hFF};
        tb = '{8'h00, 8'h01, 8'h0B, 8'h64, 8'h00, 8'hFF};
        tc = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
        er = '{8'h00, 8'h00, 8'h16, 8'h39, 8'h80, 8'hFF};
        ec = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        for (int i = 0; i < 6; i++) begin
            apply({120'd0, ta[i]}, {120'd0, tb[i]}, tc[i]);
            n_checks++;
            if (r8 !== er[i]) $display("FAIL w8_result[%0d]: got %h want %h", i, r8, er[i]);
            else n_pass++;
            n_checks++;
            if (co8 !== ec[i]) $display("FAIL w8_carry[%0d]: got %b want %b", i, co8, ec[i]);
            else n_pass++;
        end
    endtask

    // All-ones + 1 wraps to 0 with carry; all-ones + all-ones + 1 gives all-ones with carry.
    task automatic test_wrap();
        apply({128{1'b1}}, 128'd1, 1'b0);
        n_checks++; if ({co4, r4} !== 5'h10) $display("FAIL wrap4: got %h want 10", {co4, r4});
        else n_pass++;
        n_checks++; if ({co8, r8} !== 9'h100) $display("FAIL wrap8: got %h want 100", {co8, r8});
        else n_pass++;
        n_checks++; if (r16 !== 16'd0 || co16 !== 1'b1)
            $display("FAIL wrap16: got %b/%h want 1/0", co16, r16);
        else n_pass++;
        n_checks++; if (r32 !== 32'd0 || co32 !== 1'b1)
            $display("FAIL wrap32: got %b/%h want 1/0", co32, r32);
        else n_pass++;
        n_checks++; if (r64 !== 64'd0 || co64 !== 1'b1)
            $display("FAIL wrap64: got %b/%h want 1/0", co64, r64);
        else n_pass++;
        n_checks++; if (r128 !== 128'd0 || co128 !== 1'b1)
            $display("FAIL wrap128: got %b/%h want 1/0", co128, r128);
        else n_pass++;

        apply({128{1'b1}}, {128{1'b1}}, 1'b1);
        n_checks++; if ({co4, r4} !== 5'h1F) $display("FAIL ones4: got %h want 1f", {co4, r4});
        else n_pass++;
        n_checks++; if ({co8, r8} !== 9'h1FF) $display("FAIL ones8: got %h want 1ff", {co8, r8});
        else n_pass++;
        n_checks++; if (r16 !== {16{1'b1}} || co16 !== 1'b1)
            $display("FAIL ones16: got %b/%h want 1/all-ones", co16, r16);
        else n_pass++;
        n_checks++; if (r32 !== {32{1'b1}} || co32 !== 1'b1)
            $display("FAIL ones32: got %b/%h want 1/all-ones", co32, r32);
        else n_pass++;
        n_checks++; if (r64 !== {64{1'b1}} || co64 !== 1'b1)
            $display("FAIL ones64: got %b/%h want 1/all-ones", co64, r64);
        else n_pass++;
        n_checks++; if (r128 !== {128{1'b1}} || co128 !== 1'b1)
            $display("FAIL ones128: got %b/%h want 1/all-ones", co128, r128);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [127:0] a;
        logic [127:0] b;
        logic         c;
        logic [4:0]   e4;
        logic [8:0]   e8;
        logic [16:0]  e16;
        logic [32:0]  e32;
        logic [64:0]  e64;
        logic [128:0] e128;
        for (int i = 0; i < 10000; i++) begin
            a = {$urandom(), $urandom(), $urandom(), $urandom()};
            b = {$urandom(), $urandom(), $urandom(), $urandom()};
            c = 1'($urandom_range(0, 1));
            // Full-propagate operands: carryin must travel the whole width.
            if (i % 4 == 0) b = ~a;
            apply(a, b, c);
            e4   = {1'b0, a[3:0]}  + {1'b0, b[3:0]}  + {4'd0, c};
            e8   = {1'b0, a[7:0]}  + {1'b0, b[7:0]}  + {8'd0, c};
            e16  = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, c};
            e32  = {1'b0, a[31:0]} + {1'b0, b[31:0]} + {32'd0, c};
            e64  = {1'b0, a[63:0]} + {1'b0, b[63:0]} + {64'd0, c};
            e128 = {1'b0, a}       + {1'b0, b}       + {128'd0, c};
            n_checks++; if ({co4, r4} !== e4)
                $display("FAIL rand4[%0d]: got %h want %h", i, {co4, r4}, e4);
            else n_pass++;
            n_checks++; if ({co8, r8} !== e8)
                $display("FAIL rand8[%0d]: got %h want %h", i, {co8, r8}, e8);
            else n_pass++;
            n_checks++; if ({co16, r16} !== e16)
                $display("FAIL rand16[%0d]: got %h want %h", i, {co16, r16}, e16);
            else n_pass++;
            n_checks++; if ({co32, r32} !== e32)
                $display("FAIL rand32[%0d]: got %h want %h", i, {co32, r32}, e32);
            else n_pass++;
            n_checks++; if ({co64, r64} !== e64)
                $display("FAIL rand64[%0d]: got %h want %h", i, {co64, r64}, e64);
            else n_pass++;
            n_checks++; if ({co128, r128} !== e128)
                $display("FAIL rand128[%0d]: got %h want %h", i, {co128, r128}, e128);
            else n_pass++;
        end
    endtask

`ifdef CLA_OUTREG_EN
    task automatic test_outreg();
        // Reset held two edges with live inputs: outputs stay cleared.
        a_v   = 128'hFF;
        b_v   = 128'h01;
        cin_v = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (r8 !== 8'h00 || co8 !== 1'b0)
            $display("FAIL outreg_reset: got %b/%h want 0/00", co8, r8);
        else n_pass++;
        // Release reset; nothing captured until the next edge.
        reset = 1'b1;
        #1;
        n_checks++;
        if (co8 !== 1'b0) $display("FAIL outreg_pre_edge: got %b want 0", co8);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (r8 !== 8'h00 || co8 !== 1'b1)
            $display("FAIL outreg_capture: got %b/%h want 1/00", co8, r8);
        else n_pass++;
        // New inputs do not show before the next edge (exactly one cycle latency).
        a_v = 128'h0B;
        b_v = 128'h0B;
        #1;
        n_checks++;
        if (r8 !== 8'h00 || co8 !== 1'b1)
            $display("FAIL outreg_hold: got %b/%h want 1/00", co8, r8);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (r8 !== 8'h16 || co8 !== 1'b0)
            $display("FAIL outreg_next: got %b/%h want 0/16", co8, r8);
        else n_pass++;
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (r8 !== 8'h00 || co8 !== 1'b0)
            $display("FAIL outreg_rereset: got %b/%h want 0/00", co8, r8);
        else n_pass++;
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (r8 !== 8'h16 || co8 !== 1'b0)
            $display("FAIL outreg_resume: got %b/%h want 0/16", co8, r8);
        else n_pass++;
    endtask
`else
    task automatic test_reset_no_effect();
        reset = 1'b1;
        apply(128'h0B, 128'h0B, 1'b0);
        n_checks++;
        if (r8 !== 8'h16 || co8 !== 1'b0)
            $display("FAIL noeffect_before: got %b/%h want 0/16", co8, r8);
        else n_pass++;
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (r8 !== 8'h16 || co8 !== 1'b0)
            $display("FAIL noeffect_reset: got %b/%h want 0/16", co8, r8);
        else n_pass++;
        // Inputs still flow straight through while reset is low.
        a_v = 128'hFF;
        b_v = 128'h01;
        #1;
        n_checks++;
        if (r8 !== 8'h00 || co8 !== 1'b1)
            $display("FAIL noeffect_comb: got %b/%h want 1/00", co8, r8);
        else n_pass++;
        reset = 1'b1;
    endtask
`endif

    initial begin
        reset = 1'b0;
        a_v   = '0;
        b_v   = '0;
        cin_v = 1'b0;
        test_reset();
        test_width4();
        test_width8();
        test_wrap();
`ifdef CLA_OUTREG_EN
        test_outreg();
`else
        test_reset_no_effect();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
